// File: rtl/seven_seg_scan_controller_pkg.sv
// seven_seg_scan_controller_pkg: shared FSM states, reset constants and hex segment table
package seven_seg_scan_controller_pkg;
  typedef enum logic {ST_GUARD, ST_SHOW} state_t;
  localparam logic [7:0] SEG_RESET = 8'h00;
  // Active-high {g,f,e,d,c,b,a}; entry 0 sits in the low 7 bits.
  localparam logic [111:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  function automatic logic [6:0] hex_segments(input logic [3:0] h);
    return SEG_TABLE[7*h +: 7];
  endfunction
endpackage

// File: rtl/seven_seg_scan_controller_decoder.sv
// Hex_to_7seg_Decoder: combinational hex nibble plus dp to {dp, segments}
module Hex_to_7seg_Decoder
  import seven_seg_scan_controller_pkg::*;
(
  input  logic [3:0] Hex,
  input  logic       dp,
  output logic [7:0] S
);
  assign S = {dp, hex_segments(Hex)};
endmodule

// File: rtl/seven_seg_scan_controller.sv
// seven_seg_scan_controller: double-buffered multiplexed 7-segment scanner with guard blanking and leading-zero suppression
module seven_seg_scan_controller
  import seven_seg_scan_controller_pkg::*;
#(
  parameter  int NUM_DIGITS    = 4,
  parameter  int TICK_DIV      = 50000,
  parameter  int GUARD         = 16,
  parameter  int AN_ACTIVE_LOW = 1,
  localparam int DW            = $clog2(NUM_DIGITS),
  localparam int CW            = $clog2(TICK_DIV)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg,
  output logic [DW-1:0]           digit_idx,
  output logic                    upd_done
);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  state_t state;
  logic [CW-1:0] cnt;
  logic [4*NUM_DIGITS-1:0] act_val, sh_val;
  logic [NUM_DIGITS-1:0] act_dp, sh_dp, blank, one_hot;
  logic pending, slot_end, boundary, show_next, zero_run;
  logic [7:0] dec_out;
  assign slot_end  = cnt == CW'(TICK_DIV - 1);
  assign boundary  = slot_end && digit_idx == DW'(NUM_DIGITS - 1);
  assign show_next = cnt == CW'(GUARD - 1) || (state == ST_SHOW && !slot_end);
  assign one_hot   = NUM_DIGITS'(1) << digit_idx;
  // Scan from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    zero_run = lz_en;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && act_val[4*i +: 4] == 4'h0 && !act_dp[i];
      blank[i] = zero_run;
    end
  end
  Hex_to_7seg_Decoder u_dec (
    .Hex(act_val[4*digit_idx +: 4]),
    .dp (act_dp[digit_idx]),
    .S  (dec_out)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_GUARD;
      cnt       <= '0;
      digit_idx <= '0;
      an        <= AN_OFF;
      seg       <= SEG_RESET;
      upd_done  <= 1'b0;
      act_val   <= '0;
      act_dp    <= '0;
      sh_val    <= '0;
      sh_dp     <= '0;
      pending   <= 1'b0;
    end else begin
      cnt   <= slot_end ? '0 : cnt + 1'b1;
      state <= show_next ? ST_SHOW : ST_GUARD;
      if (slot_end) digit_idx <= (digit_idx == DW'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      an       <= (show_next && !blank[digit_idx]) ? one_hot ^ AN_OFF : AN_OFF;
      seg      <= dec_out;
      upd_done <= boundary && pending;
      // The boundary takes the older shadow before a coincident load overwrites it.
      if (boundary && pending) begin
        act_val <= sh_val;
        act_dp  <= sh_dp;
      end
      if (load) begin
        sh_val <= value_in;
        sh_dp  <= dp_in;
      end
      pending <= load || (pending && !boundary);
    end
  end
endmodule
